shift_register: RTL and testbench

SHIFT_REGISTER -- requirements
Module: shift_register

---
 rtl/shift_register_pkg.sv | 14 +
 rtl/shift_register_crc_lfsr.sv | 41 ++++
 rtl/shift_register.sv | 109 ++++++++++
 tb/tb_shift_register.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/shift_register_pkg.sv
// Shared types and default constants for the serial CRC shift register.
package shift_register_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int unsigned DEF_WIDTH = 8;
    localparam logic [7:0]  DEF_SEED  = 8'hD8;
    localparam logic [7:0]  DEF_TAPS  = 8'h44;

endpackage

// File: rtl/shift_register_crc_lfsr.sv
// CRC/LFSR state register with synchronous load, absorb (message bit) and
// zero-filled right-shift (frame output) controls.
module crc_lfsr
    import shift_register_pkg::*;
#(
    parameter int unsigned      WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED),
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             absorb,
    input  logic             shift,
    input  logic             din,
    output logic [WIDTH-1:0] lfsr
);

    logic             fb;
    logic [WIDTH-1:0] absorb_next;

    always_comb begin
        fb          = din ^ lfsr[0];
        absorb_next = '0;
        for (int unsigned i = 0; i < WIDTH - 1; i++) begin
            absorb_next[i] = lfsr[i+1] ^ (TAPS[i] & fb);
        end
        absorb_next[WIDTH-1] = fb;
    end

    always_ff @(posedge clk) begin
        if (rst || load) begin
            lfsr <= SEED;
        end else if (absorb) begin
            lfsr <= absorb_next;
        end else if (shift) begin
            lfsr <= lfsr >> 1;
        end
    end

endmodule

// File: rtl/shift_register.sv
// Serial CRC generator: absorbs Data while Active, then emits WIDTH CRC bits
// LSB-first with Valid. Define CRC_ECHO_EN to echo Data on CRC while absorbing.
module shift_register
    import shift_register_pkg::*;
#(
    parameter int unsigned      WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED),
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS)
) (
    input  logic CLK,
    input  logic RST,
    input  logic Data,
    input  logic Active,
    output logic CRC,
    output logic Valid
);

    localparam int unsigned      CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_MAX = CW'(WIDTH);
`ifdef CRC_ECHO_EN
    localparam logic             ECHO    = 1'b1;
`else
    localparam logic             ECHO    = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             crc_d, valid_d;
    logic             load, absorb, shift;
    logic [WIDTH-1:0] lfsr;

    crc_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (SEED),
        .TAPS  (TAPS)
    ) u_lfsr (
        .clk    (CLK),
        .rst    (RST),
        .load   (load),
        .absorb (absorb),
        .shift  (shift),
        .din    (Data),
        .lfsr   (lfsr)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        crc_d   = 1'b0;
        valid_d = 1'b0;
        load    = 1'b0;
        absorb  = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Active) begin
                    absorb  = 1'b1;
                    crc_d   = ECHO & Data;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (Active) begin
                    absorb = 1'b1;
                    crc_d  = ECHO & Data;
                end else begin
                    // First CRC bit leaves on the same edge that ends the message.
                    crc_d   = lfsr[0];
                    valid_d = 1'b1;
                    shift   = 1'b1;
                    cnt_d   = CW'(1);
                    state_d = OUT;
                end
            end
            OUT: begin
                if (cnt_q < CNT_MAX) begin
                    crc_d   = lfsr[0];
                    valid_d = 1'b1;
                    shift   = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end else begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                load    = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            CRC     <= 1'b0;
            Valid   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            CRC     <= crc_d;
            Valid   <= valid_d;
        end
    end

endmodule

// File: tb/tb_shift_register.sv
// Directed bench for shift_register: reset, echo, one- and two-bit messages,
// mid-frame reset and Active re-asserted during the output frame.
module tb_shift_register;
    import shift_register_pkg::*;

`ifdef CRC_ECHO_EN
    localparam logic ECHO = 1'b1;
`else
    localparam logic ECHO = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST, Data, Active, CRC, Valid;
    int   vectors = 0;
    int   miscompares = 0;

    shift_register #(
        .WIDTH (8),
        .SEED  (8'hD8),
        .TAPS  (8'h44)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .Data   (Data),
        .Active (Active),
        .CRC    (CRC),
        .Valid  (Valid)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drives the Active=0 edge that ends a message, then checks all WIDTH frame
    // bits and the return to IDLE; act_in/data_in are presented during OUT.
    task automatic frame(input string tag, input logic [7:0] exp,
                         input logic act_in, input logic data_in);
        logic [7:0] e;
        e = exp;
        Active = 1'b0;
        tick();
        check({tag, " valid0"}, 32'(Valid), 32'd1);
        check({tag, " crc0"}, 32'(CRC), 32'(e[0]));
        Active = act_in;
        Data   = data_in;
        for (int i = 1; i < 8; i++) begin
            tick();
            check($sformatf("%s valid%0d", tag, i), 32'(Valid), 32'd1);
            check($sformatf("%s crc%0d", tag, i), 32'(CRC), 32'(e[i]));
        end
        tick();
        check({tag, " end valid"}, 32'(Valid), 32'd0);
        check({tag, " end crc"}, 32'(CRC), 32'd0);
        check({tag, " end lfsr"}, 32'(dut.lfsr), 32'hD8);
        check({tag, " end state"}, 32'(dut.state_q), 32'(IDLE));
    endtask

    initial begin
        RST = 1'b1; Active = 1'b0; Data = 1'b0;
        tick();
        tick();
        check("rst crc", 32'(CRC), 32'd0);
        check("rst valid", 32'(Valid), 32'd0);
        check("rst lfsr", 32'(dut.lfsr), 32'hD8);
        check("rst state", 32'(dut.state_q), 32'(IDLE));

        RST = 1'b0;
        tick();
        check("idle crc", 32'(CRC), 32'd0);
        check("idle valid", 32'(Valid), 32'd0);
        check("idle lfsr", 32'(dut.lfsr), 32'hD8);

        // Two-bit message 1,0: D8 -> A8 -> 54
        Active = 1'b1; Data = 1'b1;
        tick();
        check("echo1 crc", 32'(CRC), 32'(ECHO));
        check("echo1 valid", 32'(Valid), 32'd0);
        Data = 1'b0;
        tick();
        check("echo0 crc", 32'(CRC), 32'd0);
        check("echo0 valid", 32'(Valid), 32'd0);
        check("msg10 lfsr", 32'(dut.lfsr), 32'h54);
        frame("msg10", 8'h54, 1'b0, 1'b0);

        // One-bit message Data=1 -> A8
        Active = 1'b1; Data = 1'b1;
        tick();
        check("msg1 lfsr", 32'(dut.lfsr), 32'hA8);
        frame("msg1", 8'hA8, 1'b0, 1'b0);

        // One-bit message Data=0 -> 6C
        Active = 1'b1; Data = 1'b0;
        tick();
        check("msg0 lfsr", 32'(dut.lfsr), 32'h6C);
        frame("msg0", 8'h6C, 1'b0, 1'b0);

        // Reset after the third OUT bit aborts the frame
        Active = 1'b1; Data = 1'b1;
        tick();
        Active = 1'b0;
        tick();
        tick();
        tick();
        check("pre-rst valid", 32'(Valid), 32'd1);
        RST = 1'b1;
        tick();
        check("midrst valid", 32'(Valid), 32'd0);
        check("midrst crc", 32'(CRC), 32'd0);
        check("midrst state", 32'(dut.state_q), 32'(IDLE));
        check("midrst lfsr", 32'(dut.lfsr), 32'hD8);
        RST = 1'b0;
        tick();
        check("postrst valid", 32'(Valid), 32'd0);
        Active = 1'b1; Data = 1'b1;
        tick();
        frame("postrst", 8'hA8, 1'b0, 1'b0);

        // Active held high during OUT: frame completes, new message starts from IDLE
        Active = 1'b1; Data = 1'b0;
        tick();
        frame("reassert", 8'h6C, 1'b1, 1'b1);
        tick();
        check("restart crc", 32'(CRC), 32'(ECHO));
        check("restart valid", 32'(Valid), 32'd0);
        check("restart state", 32'(dut.state_q), 32'(ACC));
        check("restart lfsr", 32'(dut.lfsr), 32'hA8);
        frame("restart", 8'hA8, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
